pipe_stage_fifo: RTL

Parametrised elastic pipeline register for the inter-stage links of the five-stage core (fetch->decode->execute->memory->writeback). It replaces the fixed single-slot struct latches with a DEPTH-entry buffer that carries an opaque packed payload of WIDTH bits. The buffer uses valid/ready handshakes, a synchronous flush for branch and exception squash, and an optional fall-through mode for zero-latency forwarding when empty. One instance sits on each stage boundary; the payload is the packed stage struct cast to bits.

---
 rtl/pipe_stage_fifo.sv | 104 ++++++++++
 1 files changed

// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: elastic pipeline register between two core stages.
// It holds up to DEPTH opaque WIDTH-bit payloads and uses valid/ready
// handshakes on both sides. A synchronous flush squashes all stored entries
// for branch and exception recovery.
//
// Parameters
//   WIDTH       payload width in bits (>= 1)
//   DEPTH       number of storage entries (>= 1, need not be a power of two)
//   FALLTHROUGH 0: registered output. 1: when the buffer is empty, the input
//               is presented combinationally at the output.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   flush      discards every stored entry and any concurrent input
//   in_valid   upstream offers in_data
//   in_ready   buffer accepts in_data this cycle
//   in_data    payload from upstream
//   out_valid  out_data holds a valid entry
//   out_ready  downstream consumes out_data this cycle
//   out_data   head payload, 0 when out_valid is low
//   count      number of stored entries
module pipe_stage_fifo #(
  parameter int WIDTH       = 64,
  parameter int DEPTH       = 2,
  parameter int FALLTHROUGH = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  logic empty;
  logic bypass;
  logic push;
  logic pop;
  logic store;
  logic deq;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (count == '0);
  assign bypass = (FALLTHROUGH != 0) && empty;

  // in_ready looks only at occupancy and flush. A pop in the same cycle does
  // not free a slot, so there is no path from out_ready to in_ready.
  assign in_ready = (count != FULL) && !flush;

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    if (bypass) begin
      out_valid = in_valid && !flush;
      if (out_valid) out_data = in_data;
    end else begin
      out_valid = !empty && !flush;
      if (out_valid) out_data = mem[rd_ptr];
    end
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // In bypass mode a simultaneous push and pop is forwarded straight through.
  // Nothing is written to storage and the read pointer does not move.
  assign store = push && !(bypass && pop);
  assign deq   = pop && !bypass;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (store) wr_ptr <= next_ptr(wr_ptr);
      if (deq)   rd_ptr <= next_ptr(rd_ptr);
      if (store && !deq)      count <= count + CW'(1);
      else if (deq && !store) count <= count - CW'(1);
    end
  end

  // Storage needs no reset; entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (!reset && store) mem[wr_ptr] <= in_data;
  end

endmodule
